// File: rtl/axi_conf_pkg.sv
// Shared AXI4 channel payloads and request/response bundles for the cut connector.
// Struct field widths are fixed here; connector width parameters must match them.
package axi_conf;

  localparam int unsigned AXI_DATA_WIDTH = 64;
  localparam int unsigned AXI_ADDR_WIDTH = 64;
  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_USER_WIDTH = 1;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam int unsigned CUT_AW = 0;
  localparam int unsigned CUT_W  = 1;
  localparam int unsigned CUT_B  = 2;
  localparam int unsigned CUT_AR = 3;
  localparam int unsigned CUT_R  = 4;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [3:0]                region;
    logic [AXI_USER_WIDTH-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
    logic [3:0]                qos;
    logic [3:0]                region;
    logic [AXI_USER_WIDTH-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
    logic [AXI_USER_WIDTH-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [1:0]                resp;
    logic [AXI_USER_WIDTH-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
    logic [AXI_USER_WIDTH-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_master_cut_connector_slice.sv
// Generic valid/ready channel stage: either a 2-entry spill register (1-cycle latency,
// full throughput) or plain wires.
module axi_chan_slice #(
  parameter type T      = logic,
  parameter bit  BYPASS = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic empty_o
);

  if (BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign empty_o = 1'b1;
  end else begin : g_cut
    logic a_full_q, b_full_q;
    T     a_q, b_q;
    logic a_drain, in_fire;

    assign a_drain = a_full_q && ready_i;
    assign in_fire = valid_i && !b_full_q;

    // Entry a always feeds the output; b only fills when a is stuck, so upstream
    // ready depends on registered state alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
        a_q      <= '0;
        b_q      <= '0;
      end else if (b_full_q) begin
        if (a_drain) begin
          a_q      <= b_q;
          b_full_q <= 1'b0;
        end
      end else if (in_fire) begin
        if (!a_full_q || a_drain) begin
          a_q      <= data_i;
          a_full_q <= 1'b1;
        end else begin
          b_q      <= data_i;
          b_full_q <= 1'b1;
        end
      end else if (a_drain) begin
        a_full_q <= 1'b0;
      end
    end

    assign ready_o = !b_full_q;
    assign valid_o = a_full_q;
    assign data_o  = a_q;
    assign empty_o = !a_full_q;
  end

endmodule

// File: rtl/axi_master_cut_connector.sv
// Drives a flattened AXI4 master port from an axi_conf req/resp pair with optional
// per-channel register cuts and per-direction outstanding-burst limiting.
module axi_master_cut_connector
  import axi_conf::*;
#(
  parameter int unsigned DATA_WIDTH  = axi_conf::AXI_DATA_WIDTH,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH  = axi_conf::AXI_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH    = axi_conf::AXI_ID_WIDTH,
  parameter int unsigned USER_WIDTH  = axi_conf::AXI_USER_WIDTH,
  parameter logic [4:0]  CUT_MASK    = 5'b11111,
  parameter int unsigned MAX_WR_TXNS = 8,
  parameter int unsigned MAX_RD_TXNS = 8,
  localparam int unsigned WR_CW      = $clog2(MAX_WR_TXNS + 1),
  localparam int unsigned RD_CW      = $clog2(MAX_RD_TXNS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  axi_conf::req_t        axi_req_i,
  output axi_conf::resp_t       axi_resp_o,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic [USER_WIDTH-1:0] m_axi_awuser,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic [USER_WIDTH-1:0] m_axi_wuser,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic [USER_WIDTH-1:0] m_axi_buser,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic [USER_WIDTH-1:0] m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic [USER_WIDTH-1:0] m_axi_ruser,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic [WR_CW-1:0]      wr_outstanding_o,
  output logic [RD_CW-1:0]      rd_outstanding_o,
  output logic                  idle_o
);

  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_TXNS);
  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_TXNS);

  aw_chan_t aw_m;
  ar_chan_t ar_m;
  w_chan_t  w_m;
  b_chan_t  b_in, b_up;
  r_chan_t  r_in, r_up;
  logic     aw_m_valid, aw_m_ready, ar_m_valid, ar_m_ready;
  logic     aw_up_ready, w_up_ready, ar_up_ready, b_up_valid, r_up_valid;
  logic     wr_room, rd_room, wr_inc, wr_dec, rd_inc, rd_dec;
  logic [4:0] slice_empty;
  logic [WR_CW-1:0] wr_cnt_q;
  logic [RD_CW-1:0] rd_cnt_q;

  axi_chan_slice #(.T(aw_chan_t), .BYPASS(!CUT_MASK[CUT_AW])) u_aw_slice (
    .clk_i, .rst_ni,
    .valid_i(axi_req_i.aw_valid), .ready_o(aw_up_ready), .data_i(axi_req_i.aw),
    .valid_o(aw_m_valid), .ready_i(aw_m_ready), .data_o(aw_m), .empty_o(slice_empty[CUT_AW])
  );

  axi_chan_slice #(.T(w_chan_t), .BYPASS(!CUT_MASK[CUT_W])) u_w_slice (
    .clk_i, .rst_ni,
    .valid_i(axi_req_i.w_valid), .ready_o(w_up_ready), .data_i(axi_req_i.w),
    .valid_o(m_axi_wvalid), .ready_i(m_axi_wready), .data_o(w_m), .empty_o(slice_empty[CUT_W])
  );

  axi_chan_slice #(.T(b_chan_t), .BYPASS(!CUT_MASK[CUT_B])) u_b_slice (
    .clk_i, .rst_ni,
    .valid_i(m_axi_bvalid), .ready_o(m_axi_bready), .data_i(b_in),
    .valid_o(b_up_valid), .ready_i(axi_req_i.b_ready), .data_o(b_up), .empty_o(slice_empty[CUT_B])
  );

  axi_chan_slice #(.T(ar_chan_t), .BYPASS(!CUT_MASK[CUT_AR])) u_ar_slice (
    .clk_i, .rst_ni,
    .valid_i(axi_req_i.ar_valid), .ready_o(ar_up_ready), .data_i(axi_req_i.ar),
    .valid_o(ar_m_valid), .ready_i(ar_m_ready), .data_o(ar_m), .empty_o(slice_empty[CUT_AR])
  );

  axi_chan_slice #(.T(r_chan_t), .BYPASS(!CUT_MASK[CUT_R])) u_r_slice (
    .clk_i, .rst_ni,
    .valid_i(m_axi_rvalid), .ready_o(m_axi_rready), .data_i(r_in),
    .valid_o(r_up_valid), .ready_i(axi_req_i.r_ready), .data_o(r_up), .empty_o(slice_empty[CUT_R])
  );

  always_comb begin
    b_in      = '0;
    b_in.id   = m_axi_bid;
    b_in.resp = m_axi_bresp;
    b_in.user = m_axi_buser;
    r_in      = '0;
    r_in.id   = m_axi_rid;
    r_in.data = m_axi_rdata;
    r_in.resp = m_axi_rresp;
    r_in.last = m_axi_rlast;
    r_in.user = m_axi_ruser;
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_up_ready;
    axi_resp_o.w_ready  = w_up_ready;
    axi_resp_o.ar_ready = ar_up_ready;
    axi_resp_o.b_valid  = b_up_valid;
    axi_resp_o.b        = b_up;
    axi_resp_o.r_valid  = r_up_valid;
    axi_resp_o.r        = r_up;
  end

  // The gate only ever holds back a new burst: once awvalid/arvalid is high the
  // registered count cannot reach the limit until that very beat handshakes.
  assign wr_room       = wr_cnt_q < WR_MAX;
  assign rd_room       = rd_cnt_q < RD_MAX;
  assign m_axi_awvalid = aw_m_valid && wr_room;
  assign aw_m_ready    = m_axi_awready && wr_room;
  assign m_axi_arvalid = ar_m_valid && rd_room;
  assign ar_m_ready    = m_axi_arready && rd_room;

  assign m_axi_awid     = aw_m.id;
  assign m_axi_awaddr   = aw_m.addr;
  assign m_axi_awlen    = aw_m.len;
  assign m_axi_awsize   = aw_m.size;
  assign m_axi_awburst  = aw_m.burst;
  assign m_axi_awlock   = aw_m.lock;
  assign m_axi_awcache  = aw_m.cache;
  assign m_axi_awprot   = aw_m.prot;
  assign m_axi_awqos    = aw_m.qos;
  assign m_axi_awregion = aw_m.region;
  assign m_axi_awuser   = aw_m.user;
  assign m_axi_wdata    = w_m.data;
  assign m_axi_wstrb    = w_m.strb;
  assign m_axi_wlast    = w_m.last;
  assign m_axi_wuser    = w_m.user;
  assign m_axi_arid     = ar_m.id;
  assign m_axi_araddr   = ar_m.addr;
  assign m_axi_arlen    = ar_m.len;
  assign m_axi_arsize   = ar_m.size;
  assign m_axi_arburst  = ar_m.burst;
  assign m_axi_arlock   = ar_m.lock;
  assign m_axi_arcache  = ar_m.cache;
  assign m_axi_arprot   = ar_m.prot;
  assign m_axi_arqos    = ar_m.qos;
  assign m_axi_arregion = ar_m.region;
  assign m_axi_aruser   = ar_m.user;

  assign wr_inc = m_axi_awvalid && m_axi_awready;
  assign wr_dec = m_axi_bvalid && m_axi_bready;
  assign rd_inc = m_axi_arvalid && m_axi_arready;
  assign rd_dec = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  // Counters track bursts as seen by the slave; a response with nothing
  // outstanding is a protocol error and the count stays at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (wr_inc && !wr_dec) wr_cnt_q <= wr_cnt_q + WR_CW'(1);
      else if (wr_dec && !wr_inc && wr_cnt_q != '0) wr_cnt_q <= wr_cnt_q - WR_CW'(1);
      if (rd_inc && !rd_dec) rd_cnt_q <= rd_cnt_q + RD_CW'(1);
      else if (rd_dec && !rd_inc && rd_cnt_q != '0) rd_cnt_q <= rd_cnt_q - RD_CW'(1);
    end
  end

  wr_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_dec && !wr_inc && wr_cnt_q == '0));
  rd_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_dec && !rd_inc && rd_cnt_q == '0));

  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
  assign idle_o           = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (&slice_empty);

endmodule

// File: tb/tb_axi_master_cut_connector.sv
// Directed bench: one fully cut instance (write limit 2) and one pass-through instance.
module tb_axi_master_cut_connector;
  import axi_conf::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  req_t  req_c, req_p;
  resp_t resp_c, resp_p;

  // cut instance master side
  logic [3:0]  c_awid, c_arid, c_bid, c_rid;
  logic [63:0] c_awaddr, c_araddr, c_wdata, c_rdata;
  logic [7:0]  c_awlen, c_arlen, c_wstrb;
  logic [2:0]  c_awsize, c_arsize, c_awprot, c_arprot;
  logic [1:0]  c_awburst, c_arburst, c_bresp, c_rresp;
  logic        c_awlock, c_arlock, c_wlast, c_rlast;
  logic [3:0]  c_awcache, c_arcache, c_awqos, c_arqos, c_awregion, c_arregion;
  logic [0:0]  c_awuser, c_aruser, c_wuser, c_buser, c_ruser;
  logic        c_awvalid, c_awready, c_wvalid, c_wready, c_bvalid, c_bready;
  logic        c_arvalid, c_arready, c_rvalid, c_rready, c_idle;
  logic [1:0]  c_wr_out;
  logic [3:0]  c_rd_out;

  // pass-through instance master side
  logic [3:0]  p_awid, p_arid, p_bid, p_rid;
  logic [63:0] p_awaddr, p_araddr, p_wdata, p_rdata;
  logic [7:0]  p_awlen, p_arlen, p_wstrb;
  logic [2:0]  p_awsize, p_arsize, p_awprot, p_arprot;
  logic [1:0]  p_awburst, p_arburst, p_bresp, p_rresp;
  logic        p_awlock, p_arlock, p_wlast, p_rlast;
  logic [3:0]  p_awcache, p_arcache, p_awqos, p_arqos, p_awregion, p_arregion;
  logic [0:0]  p_awuser, p_aruser, p_wuser, p_buser, p_ruser;
  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
  logic        p_arvalid, p_arready, p_rvalid, p_rready, p_idle;
  logic [3:0]  p_wr_out, p_rd_out;

  axi_master_cut_connector #(.CUT_MASK(5'b11111), .MAX_WR_TXNS(2), .MAX_RD_TXNS(8)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req_c), .axi_resp_o(resp_c),
    .m_axi_awid(c_awid), .m_axi_awaddr(c_awaddr), .m_axi_awlen(c_awlen), .m_axi_awsize(c_awsize),
    .m_axi_awburst(c_awburst), .m_axi_awlock(c_awlock), .m_axi_awcache(c_awcache),
    .m_axi_awprot(c_awprot), .m_axi_awqos(c_awqos), .m_axi_awregion(c_awregion),
    .m_axi_awuser(c_awuser), .m_axi_awvalid(c_awvalid), .m_axi_awready(c_awready),
    .m_axi_wdata(c_wdata), .m_axi_wstrb(c_wstrb), .m_axi_wlast(c_wlast), .m_axi_wuser(c_wuser),
    .m_axi_wvalid(c_wvalid), .m_axi_wready(c_wready),
    .m_axi_bid(c_bid), .m_axi_bresp(c_bresp), .m_axi_buser(c_buser),
    .m_axi_bvalid(c_bvalid), .m_axi_bready(c_bready),
    .m_axi_arid(c_arid), .m_axi_araddr(c_araddr), .m_axi_arlen(c_arlen), .m_axi_arsize(c_arsize),
    .m_axi_arburst(c_arburst), .m_axi_arlock(c_arlock), .m_axi_arcache(c_arcache),
    .m_axi_arprot(c_arprot), .m_axi_arqos(c_arqos), .m_axi_arregion(c_arregion),
    .m_axi_aruser(c_aruser), .m_axi_arvalid(c_arvalid), .m_axi_arready(c_arready),
    .m_axi_rid(c_rid), .m_axi_rdata(c_rdata), .m_axi_rresp(c_rresp), .m_axi_rlast(c_rlast),
    .m_axi_ruser(c_ruser), .m_axi_rvalid(c_rvalid), .m_axi_rready(c_rready),
    .wr_outstanding_o(c_wr_out), .rd_outstanding_o(c_rd_out), .idle_o(c_idle)
  );

  axi_master_cut_connector #(.CUT_MASK(5'b00000)) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req_p), .axi_resp_o(resp_p),
    .m_axi_awid(p_awid), .m_axi_awaddr(p_awaddr), .m_axi_awlen(p_awlen), .m_axi_awsize(p_awsize),
    .m_axi_awburst(p_awburst), .m_axi_awlock(p_awlock), .m_axi_awcache(p_awcache),
    .m_axi_awprot(p_awprot), .m_axi_awqos(p_awqos), .m_axi_awregion(p_awregion),
    .m_axi_awuser(p_awuser), .m_axi_awvalid(p_awvalid), .m_axi_awready(p_awready),
    .m_axi_wdata(p_wdata), .m_axi_wstrb(p_wstrb), .m_axi_wlast(p_wlast), .m_axi_wuser(p_wuser),
    .m_axi_wvalid(p_wvalid), .m_axi_wready(p_wready),
    .m_axi_bid(p_bid), .m_axi_bresp(p_bresp), .m_axi_buser(p_buser),
    .m_axi_bvalid(p_bvalid), .m_axi_bready(p_bready),
    .m_axi_arid(p_arid), .m_axi_araddr(p_araddr), .m_axi_arlen(p_arlen), .m_axi_arsize(p_arsize),
    .m_axi_arburst(p_arburst), .m_axi_arlock(p_arlock), .m_axi_arcache(p_arcache),
    .m_axi_arprot(p_arprot), .m_axi_arqos(p_arqos), .m_axi_arregion(p_arregion),
    .m_axi_aruser(p_aruser), .m_axi_arvalid(p_arvalid), .m_axi_arready(p_arready),
    .m_axi_rid(p_rid), .m_axi_rdata(p_rdata), .m_axi_rresp(p_rresp), .m_axi_rlast(p_rlast),
    .m_axi_ruser(p_ruser), .m_axi_rvalid(p_rvalid), .m_axi_rready(p_rready),
    .wr_outstanding_o(p_wr_out), .rd_outstanding_o(p_rd_out), .idle_o(p_idle)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    req_c = '0;
    req_p = '0;
    req_c.b_ready = 1'b1;
    req_c.r_ready = 1'b1;
    {c_awready, c_wready, c_bvalid, c_arready, c_rvalid, c_rlast} = '0;
    {c_bid, c_bresp, c_buser, c_rid, c_rdata, c_rresp, c_ruser} = '0;
    {p_awready, p_wready, p_bvalid, p_arready, p_rvalid, p_rlast} = '0;
    {p_bid, p_bresp, p_buser, p_rid, p_rdata, p_rresp, p_ruser} = '0;

    // reset held for three cycles
    repeat (3) @(negedge clk);
    checkOutput("rst_awvalid", c_awvalid, 1'b0);
    checkOutput("rst_wvalid", c_wvalid, 1'b0);
    checkOutput("rst_arvalid", c_arvalid, 1'b0);
    checkOutput("rst_b_valid_up", resp_c.b_valid, 1'b0);
    checkOutput("rst_r_valid_up", resp_c.r_valid, 1'b0);
    checkOutput("rst_idle", c_idle, 1'b1);
    checkOutput("rst_wr_out", c_wr_out, 2'd0);
    checkOutput("rst_rd_out", c_rd_out, 4'd0);
    checkOutput("rst_idle_p", p_idle, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_aw_ready", resp_c.aw_ready, 1'b1);
    checkOutput("rel_w_ready", resp_c.w_ready, 1'b1);
    checkOutput("rel_ar_ready", resp_c.ar_ready, 1'b1);

    // 16 back-to-back W beats, each one cycle behind upstream
    c_wready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput("w_valid", c_wvalid, 1'b1);
        checkOutput("w_data", c_wdata, 64'hA000 + 64'(i - 1));
        checkOutput("w_last", c_wlast, (i == 16));
      end
      if (i < 16) begin
        req_c.w_valid = 1'b1;
        req_c.w.data = 64'hA000 + 64'(i);
        req_c.w.strb = 8'hFF;
        req_c.w.last = (i == 15);
        #1 checkOutput("w_ready_up", resp_c.w_ready, 1'b1);
      end else begin
        req_c.w_valid = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("w_drained", c_wvalid, 1'b0);

    // AR back-pressure: first request parked, second in spill entry
    c_arready = 1'b0;
    req_c.ar_valid = 1'b1;
    req_c.ar.addr = 64'h1000;
    #1 checkOutput("ar_ready_first", resp_c.ar_ready, 1'b1);
    @(negedge clk);
    checkOutput("ar_valid_bp", c_arvalid, 1'b1);
    checkOutput("ar_addr_bp", c_araddr, 64'h1000);
    req_c.ar.addr = 64'h2000;
    #1 checkOutput("ar_ready_second", resp_c.ar_ready, 1'b1);
    @(negedge clk);
    req_c.ar_valid = 1'b0;
    checkOutput("ar_ready_full", resp_c.ar_ready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("ar_addr_stable", c_araddr, 64'h1000);
      checkOutput("ar_valid_stable", c_arvalid, 1'b1);
    end
    @(negedge clk);
    c_arready = 1'b1;
    #1 checkOutput("ar_release_addr", c_araddr, 64'h1000);
    @(negedge clk);
    checkOutput("ar_second_addr", c_araddr, 64'h2000);
    checkOutput("ar_rd_out_1", c_rd_out, 4'd1);
    checkOutput("ar_ready_back", resp_c.ar_ready, 1'b1);
    @(negedge clk);
    c_arready = 1'b0;
    checkOutput("ar_drained", c_arvalid, 1'b0);
    checkOutput("ar_rd_out_2", c_rd_out, 4'd2);
    c_rvalid = 1'b1;
    c_rlast = 1'b1;
    c_rdata = 64'h55;
    @(negedge clk);
    checkOutput("r_rd_out_1", c_rd_out, 4'd1);
    checkOutput("r_valid_up", resp_c.r_valid, 1'b1);
    checkOutput("r_data_up", resp_c.r.data, 64'h55);
    c_rdata = 64'h66;
    @(negedge clk);
    c_rvalid = 1'b0;
    checkOutput("r_rd_out_0", c_rd_out, 4'd0);
    checkOutput("r_data_up2", resp_c.r.data, 64'h66);
    @(negedge clk);
    checkOutput("idle_after_reads", c_idle, 1'b1);

    // write limit of two outstanding bursts
    c_awready = 1'b1;
    req_c.aw_valid = 1'b1;
    req_c.aw.id = 4'd1;
    req_c.aw.addr = 64'h100;
    @(negedge clk);
    checkOutput("aw1_valid", c_awvalid, 1'b1);
    checkOutput("aw1_id", c_awid, 4'd1);
    req_c.aw.id = 4'd2;
    @(negedge clk);
    checkOutput("aw_wr_out_1", c_wr_out, 2'd1);
    checkOutput("aw2_id", c_awid, 4'd2);
    req_c.aw.id = 4'd3;
    @(negedge clk);
    checkOutput("aw_wr_out_2", c_wr_out, 2'd2);
    checkOutput("aw3_gated", c_awvalid, 1'b0);
    req_c.aw_valid = 1'b0;
    @(negedge clk);
    checkOutput("aw3_still_gated", c_awvalid, 1'b0);
    checkOutput("idle_busy_wr", c_idle, 1'b0);
    c_bvalid = 1'b1;
    c_bid = 4'd1;
    #1 checkOutput("b_ready_m", c_bready, 1'b1);
    @(negedge clk);
    c_bvalid = 1'b0;
    checkOutput("b1_wr_out", c_wr_out, 2'd1);
    checkOutput("aw3_issue", c_awvalid, 1'b1);
    checkOutput("aw3_id", c_awid, 4'd3);
    checkOutput("b1_valid_up", resp_c.b_valid, 1'b1);
    checkOutput("b1_id_up", resp_c.b.id, 4'd1);
    @(negedge clk);
    checkOutput("aw3_wr_out_2", c_wr_out, 2'd2);
    checkOutput("aw3_done", c_awvalid, 1'b0);
    c_bvalid = 1'b1;
    c_bid = 4'd2;
    @(negedge clk);
    checkOutput("b2_wr_out", c_wr_out, 2'd1);
    c_bid = 4'd3;
    @(negedge clk);
    c_bvalid = 1'b0;
    checkOutput("b3_wr_out", c_wr_out, 2'd0);
    checkOutput("b3_idle_slice_busy", c_idle, 1'b0);
    @(negedge clk);
    checkOutput("idle_after_writes", c_idle, 1'b1);

    // read burst of four beats: only rlast retires it
    c_arready = 1'b1;
    req_c.ar_valid = 1'b1;
    req_c.ar.addr = 64'h3000;
    req_c.ar.len = 8'd3;
    @(negedge clk);
    checkOutput("ar_len_valid", c_arvalid, 1'b1);
    checkOutput("ar_len", c_arlen, 8'd3);
    req_c.ar_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("burst_rd_out", c_rd_out, 4'd1);
      c_rvalid = 1'b1;
      c_rdata = 64'(i);
      c_rlast = (i == 4);
    end
    @(negedge clk);
    c_rvalid = 1'b0;
    checkOutput("burst_rd_out_0", c_rd_out, 4'd0);
    checkOutput("burst_idle_busy", c_idle, 1'b0);
    checkOutput("burst_last_up", resp_c.r.last, 1'b1);
    @(negedge clk);
    checkOutput("burst_idle", c_idle, 1'b1);

    // AR handshake coinciding with R-last leaves the count unchanged
    req_c.ar_valid = 1'b1;
    req_c.ar.addr = 64'h4000;
    @(negedge clk);
    req_c.ar_valid = 1'b0;
    @(negedge clk);
    checkOutput("sim_rd_out_1", c_rd_out, 4'd1);
    req_c.ar_valid = 1'b1;
    req_c.ar.addr = 64'h5000;
    @(negedge clk);
    req_c.ar_valid = 1'b0;
    checkOutput("sim_arvalid", c_arvalid, 1'b1);
    c_rvalid = 1'b1;
    c_rlast = 1'b1;
    @(negedge clk);
    checkOutput("sim_rd_out_same", c_rd_out, 4'd1);
    @(negedge clk);
    c_rvalid = 1'b0;
    checkOutput("sim_rd_out_0", c_rd_out, 4'd0);

    // pass-through instance: all channels combinational
    @(negedge clk);
    req_p.aw_valid = 1'b1;
    req_p.aw.addr = 64'hABC;
    p_awready = 1'b1;
    #1;
    checkOutput("byp_awvalid", p_awvalid, 1'b1);
    checkOutput("byp_awaddr", p_awaddr, 64'hABC);
    checkOutput("byp_aw_ready", resp_p.aw_ready, 1'b1);
    p_awready = 1'b0;
    #1 checkOutput("byp_aw_ready_low", resp_p.aw_ready, 1'b0);
    req_p.aw_valid = 1'b0;
    #1 checkOutput("byp_awvalid_low", p_awvalid, 1'b0);
    @(negedge clk);
    req_p.w_valid = 1'b1;
    req_p.w.data = 64'hDEAD;
    p_wready = 1'b1;
    #1;
    checkOutput("byp_wvalid", p_wvalid, 1'b1);
    checkOutput("byp_wdata", p_wdata, 64'hDEAD);
    checkOutput("byp_w_ready", resp_p.w_ready, 1'b1);
    req_p.w_valid = 1'b0;
    p_wready = 1'b0;
    @(negedge clk);
    p_bvalid = 1'b1;
    p_bid = 4'd5;
    req_p.b_ready = 1'b1;
    #1;
    checkOutput("byp_b_valid", resp_p.b_valid, 1'b1);
    checkOutput("byp_b_id", resp_p.b.id, 4'd5);
    checkOutput("byp_bready", p_bready, 1'b1);
    p_bvalid = 1'b0;
    req_p.b_ready = 1'b0;
    @(negedge clk);
    req_p.ar_valid = 1'b1;
    req_p.ar.addr = 64'h777;
    p_arready = 1'b1;
    #1;
    checkOutput("byp_arvalid", p_arvalid, 1'b1);
    checkOutput("byp_araddr", p_araddr, 64'h777);
    checkOutput("byp_ar_ready", resp_p.ar_ready, 1'b1);
    req_p.ar_valid = 1'b0;
    p_arready = 1'b0;
    @(negedge clk);
    p_rvalid = 1'b1;
    p_rdata = 64'hBEEF;
    p_rlast = 1'b1;
    req_p.r_ready = 1'b1;
    #1;
    checkOutput("byp_r_valid", resp_p.r_valid, 1'b1);
    checkOutput("byp_r_data", resp_p.r.data, 64'hBEEF);
    checkOutput("byp_rready", p_rready, 1'b1);
    p_rvalid = 1'b0;
    req_p.r_ready = 1'b0;
    @(negedge clk);
    checkOutput("byp_idle", p_idle, 1'b1);
    checkOutput("byp_wr_out", p_wr_out, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
